fp_classify_pipe: RTL and testbench
===================================

FP_CLASSIFY_PIPE -- requirements
Module: fp_classify_pipe

Interface
REQ-001 Parameter exp_width, default 8, exponent field width.
REQ-002 Parameter mant_width, default 24, significand width including hidden bit; stored fraction = mant_width-1 bits; word width W = exp_width+mant_width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_l  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous discard of all in-flight operands.
REQ-006 in_valid  input  1  operand a is valid this cycle.
REQ-007 in_ready  output  1  block accepts operand this cycle.
REQ-008 a  input  W  operand, packed {sign, exp, frac}.
REQ-009 out_valid  output  1  class result valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 out  output  W  class mask zero-extended to W bits.

Function
REQ-012 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready on a rising edge.
REQ-013 Two registered stages S1 (field decode) and S2 (mask); each has its own valid flag.
REQ-014 S1 registers: sign, exp_ones (exp all 1s), exp_zero, frac_zero, frac_msb.
REQ-015 S2 register holds 10-bit mask built from S1 fields; out = {zeros, mask}.
REQ-016 Mask bits, exactly one set per result: 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 signalling NaN, 9 quiet NaN.
REQ-017 inf: exp_ones && frac_zero; NaN: exp_ones && !frac_zero, quiet if frac_msb=1 else signalling, sign ignored for NaN.
REQ-018 zero: exp_zero && frac_zero; subnormal: exp_zero && !frac_zero; normal: otherwise.
REQ-019 s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational from registered valids and out_ready).
REQ-020 Latency: operand accepted at edge N appears on out with out_valid at edge N+2 when no backpressure.
REQ-021 Throughput: one result per cycle with out_ready held high.
REQ-022 Stall: out_valid && !out_ready holds out and S2 stable; S1 holds if also valid; at most 2 operands in flight; no loss, no duplication, order preserved.
REQ-023 out is held stable while out_valid && !out_ready.
REQ-024 Simultaneous out transfer and S1→S2 move in the same cycle is permitted and required for full throughput.
REQ-025 flush=1: both valid flags cleared at the edge; in_valid that cycle is not captured; in_ready evaluated normally but capture suppressed.
REQ-026 Data registers need no reset; only valid flags reset; out value when out_valid=0 is don't-care but shall be driven (no X from reset path after first capture).

Reset
REQ-027 rst_l low: s1_valid=0, s2_valid=0 immediately (asynchronous), so out_valid=0, in_ready=1.
REQ-028 Reset asserted mid-operation discards all in-flight operands; no result emitted after release for pre-reset inputs.
REQ-029 First transfer allowed on the first rising edge with rst_l high.

Verification
REQ-030 Sweep with out_ready=1: a=0xFF800000→0x001, 0x3F800000→0x040, 0x80000000→0x008, 0x00000001→0x020, 0x7F800001→0x100, 0x7FC00000→0x200, each 2 cycles after accept, back-to-back.
REQ-031 Backpressure: stream 5 operands, out_ready=0 for 4 cycles after first out_valid → in_ready low after 2 held, out stable, all 5 results delivered in order after release.
REQ-032 Random out_ready toggling 1000 random operands vs reference classifier model → every mask one-hot, count and order match.
REQ-033 Flush with 2 in flight (S1, S2 valid) → next cycle out_valid=0, in_ready=1, neither result ever appears.
REQ-034 rst_l pulled low asynchronously between edges with 2 in flight → out_valid drops before next edge; after release, first new operand 0x7F800000 → 0x080 at N+2.
REQ-035 Simultaneous: out_valid=1, out_ready=1, S1 valid, in_valid=1 same cycle → all three advance, no bubble, no drop.

Source files
------------

// File: rtl/fp_classify_pipe.sv
// Two-stage floating-point classifier with valid/ready handshake on both sides.
// S1 registers the decoded exponent/fraction flags; S2 registers a 10-bit one-hot class mask.
module fp_classify_pipe #(
    parameter int exp_width  = 8,
    parameter int mant_width = 24
) (
    input  logic                              clk,
    input  logic                              rst_l,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [exp_width+mant_width-1:0]   a,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [exp_width+mant_width-1:0]   out
);

    localparam int W  = exp_width + mant_width;
    localparam int FW = mant_width - 1;

    // Bit order: -inf, -norm, -sub, -0, +0, +sub, +norm, +inf, sNaN, qNaN; NaN ignores sign.
    function automatic logic [9:0] class_mask(
        input logic sign,
        input logic exp_ones,
        input logic exp_zero,
        input logic frac_zero,
        input logic frac_msb
    );
        logic [9:0] m;
        m = 10'b00_0000_0000;
        if (exp_ones) begin
            if (frac_zero) begin
                m = sign ? 10'b00_0000_0001 : 10'b00_1000_0000;
            end else if (frac_msb) begin
                m = 10'b10_0000_0000;
            end else begin
                m = 10'b01_0000_0000;
            end
        end else if (exp_zero) begin
            if (frac_zero) begin
                m = sign ? 10'b00_0000_1000 : 10'b00_0001_0000;
            end else begin
                m = sign ? 10'b00_0000_0100 : 10'b00_0010_0000;
            end
        end else begin
            m = sign ? 10'b00_0000_0010 : 10'b00_0100_0000;
        end
        return m;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s1_sign_q, s1_sign_d;
    logic                 s1_exp_ones_q, s1_exp_ones_d;
    logic                 s1_exp_zero_q, s1_exp_zero_d;
    logic                 s1_frac_zero_q, s1_frac_zero_d;
    logic                 s1_frac_msb_q, s1_frac_msb_d;
    logic [9:0]           s2_mask_q, s2_mask_d;

    logic                 s1_adv_s;
    logic                 s2_adv_s;
    logic                 s1_load_s;
    logic                 s2_load_s;
    logic [exp_width-1:0] a_exp_s;
    logic [FW-1:0]        a_frac_s;

    // Handshake, stage advance and next-state computation for every flop.
    always_comb begin
        a_exp_s   = a[W-2 -: exp_width];
        a_frac_s  = a[FW-1:0];
        s2_adv_s  = !s2_valid_q || out_ready;
        s1_adv_s  = !s1_valid_q || s2_adv_s;
        s1_load_s = in_valid && s1_adv_s && !flush;
        s2_load_s = s1_valid_q && s2_adv_s;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_adv_s ? in_valid : s1_valid_q;
            s2_valid_d = s2_adv_s ? s1_valid_q : s2_valid_q;
        end

        if (s1_load_s) begin
            s1_sign_d      = a[W-1];
            s1_exp_ones_d  = &a_exp_s;
            s1_exp_zero_d  = ~|a_exp_s;
            s1_frac_zero_d = ~|a_frac_s;
            s1_frac_msb_d  = a_frac_s[FW-1];
        end else begin
            s1_sign_d      = s1_sign_q;
            s1_exp_ones_d  = s1_exp_ones_q;
            s1_exp_zero_d  = s1_exp_zero_q;
            s1_frac_zero_d = s1_frac_zero_q;
            s1_frac_msb_d  = s1_frac_msb_q;
        end

        if (s2_load_s) begin
            s2_mask_d = class_mask(s1_sign_q, s1_exp_ones_q, s1_exp_zero_q,
                                   s1_frac_zero_q, s1_frac_msb_q);
        end else begin
            s2_mask_d = s2_mask_q;
        end
    end

    // Valid flags are the only state cleared by reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Payload registers; contents only matter while the matching valid flag is set.
    always_ff @(posedge clk) begin
        s1_sign_q      <= s1_sign_d;
        s1_exp_ones_q  <= s1_exp_ones_d;
        s1_exp_zero_q  <= s1_exp_zero_d;
        s1_frac_zero_q <= s1_frac_zero_d;
        s1_frac_msb_q  <= s1_frac_msb_d;
        s2_mask_q      <= s2_mask_d;
    end

    assign in_ready  = s1_adv_s;
    assign out_valid = s2_valid_q;
    assign out       = {{(W-10){1'b0}}, s2_mask_q};

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Directed and randomized bench for fp_classify_pipe against a queue-based reference model.
module tb_fp_classify_pipe;

    logic        clk;
    logic        rst_l;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int checks;
    int failures;
    int edge_cnt;

    typedef struct {
        logic [31:0] mask;
        int          acc;
    } item_t;

    item_t q[$];

    fp_classify_pipe #(.exp_width(8), .mant_width(24)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IEEE-754 single classification from the raw fields.
    function automatic logic [31:0] ref_class(input logic [31:0] v);
        int unsigned ex;
        int unsigned fr;
        int          idx;
        ex = (v >> 23) & 32'hFF;
        fr = v & 32'h7F_FFFF;
        if (ex == 255) begin
            if (fr == 0) idx = v[31] ? 0 : 7;
            else if (fr >= 32'h40_0000) idx = 9;
            else idx = 8;
        end else if (ex == 0) begin
            if (fr == 0) idx = v[31] ? 3 : 4;
            else idx = v[31] ? 2 : 5;
        end else begin
            idx = v[31] ? 1 : 6;
        end
        return 32'd1 << idx;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] s, e, f;
        s = 32'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
            0: e = 32'd0;
            1: e = 32'd255;
            default: e = 32'($urandom_range(1, 254));
        endcase
        case ($urandom_range(0, 2))
            0: f = 32'd0;
            1: f = 32'($urandom_range(1, 32'h3F_FFFF));
            default: f = 32'h40_0000 | 32'($urandom_range(0, 32'h3F_FFFF));
        endcase
        return (s << 31) | (e << 23) | f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after a falling edge, check, then advance the model at the rising edge.
    task automatic cyc(input logic iv, input logic [31:0] av, input logic ordy,
                       input logic fl, output logic accepted);
        logic  exp_rdy;
        logic  exp_ov;
        logic  deliver;
        item_t it;
        in_valid  = iv;
        a         = av;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !(q.size() == 2 && !ordy);
        exp_ov  = (q.size() > 0) && (q[0].acc <= edge_cnt - 1);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            chk("out_mask", out, q[0].mask);
            chk("onehot", {31'd0, $onehot(out)}, 32'd1);
        end
        accepted = iv && exp_rdy && !fl;
        deliver  = exp_ov && ordy && !fl;
        @(posedge clk);
        edge_cnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (deliver) void'(q.pop_front());
            if (accepted) begin
                it.mask = ref_class(av);
                it.acc  = edge_cnt;
                q.push_back(it);
            end
        end
        @(negedge clk);
    endtask

    logic [31:0] sweep_ops [6];
    logic [31:0] sweep_exp [6];
    logic [31:0] bp_ops [5];
    logic        acc;
    logic [31:0] op;
    int          sent;
    int          budget;

    initial begin
        checks    = 0;
        failures  = 0;
        edge_cnt  = 0;
        rst_l     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        a         = 32'd0;
        out_ready = 1'b0;
        sweep_ops = '{32'hFF80_0000, 32'h3F80_0000, 32'h8000_0000,
                      32'h0000_0001, 32'h7F80_0001, 32'h7FC0_0000};
        sweep_exp = '{32'h001, 32'h040, 32'h008, 32'h020, 32'h100, 32'h200};
        bp_ops    = '{32'h4049_0FDB, 32'hC000_0000, 32'h807F_FFFF, 32'h7F80_0000, 32'hFFC0_0001};

        // Reset state.
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_l = 1'b1;

        // Reference model sanity against the fixed class table.
        for (int i = 0; i < 6; i++) chk("ref_table", ref_class(sweep_ops[i]), sweep_exp[i]);

        // Back-to-back sweep with out_ready high.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, sweep_ops[i], 1'b1, 1'b0, acc);
            chk("sweep_accept", {31'd0, acc}, 32'd1);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Backpressure: five operands, consumer stalls four cycles after first result.
        sent = 0;
        cyc(1'b1, bp_ops[0], 1'b1, 1'b0, acc);
        if (acc) sent++;
        cyc(1'b1, bp_ops[sent], 1'b1, 1'b0, acc);
        if (acc) sent++;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, bp_ops[sent], 1'b0, 1'b0, acc);
            if (acc) sent++;
        end
        chk("bp_held_in_flight", q.size(), 32'd2);
        budget = 0;
        while (sent < 5 && budget < 20) begin
            cyc(1'b1, bp_ops[sent], 1'b1, 1'b0, acc);
            if (acc) sent++;
            budget++;
        end
        chk("bp_all_sent", sent, 32'd5);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Flush with both stages full, then a flush that must not capture a ready operand.
        cyc(1'b1, 32'h3F80_0000, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'hBF80_0000, 1'b0, 1'b0, acc);
        chk("flush_pre_full", q.size(), 32'd2);
        cyc(1'b1, 32'h0000_0000, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);
        cyc(1'b1, 32'h7F80_0000, 1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Asynchronous reset between edges with two in flight.
        cyc(1'b1, 32'h0000_0001, 1'b0, 1'b0, acc);
        cyc(1'b1, 32'h8000_0001, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        rst_l = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        rst_l = 1'b1;
        cyc(1'b1, 32'h7F80_0000, 1'b1, 1'b0, acc);
        chk("post_rst_accept", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Random operands and random consumer backpressure.
        sent   = 0;
        budget = 0;
        op     = rand_op();
        while (sent < 1000 && budget < 20000) begin
            cyc($urandom_range(0, 3) != 0, op, $urandom_range(0, 2) != 0, 1'b0, acc);
            if (acc) begin
                sent++;
                op = rand_op();
            end
            budget++;
        end
        chk("rand_all_sent", sent, 32'd1000);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
